// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the RV32I multicycle control unit.
// Holds the FSM state enum, opcode constants, ALU control/op codes,
// datapath select encodings and the immediate-format decoder.
package riscv_mc_pkg;

    localparam int unsigned OP_W   = 7;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned ALU_W  = 3;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned AOP_W  = 2;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_JAL,
        S_ALUWB,
        S_BEQ
    } state_t;

    localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;
    localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b101;

    localparam logic [AOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [AOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [AOP_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] IMM_I = 2'b00;
    localparam logic [SEL_W-1:0] IMM_S = 2'b01;
    localparam logic [SEL_W-1:0] IMM_B = 2'b10;
    localparam logic [SEL_W-1:0] IMM_J = 2'b11;

    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_A     = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_WD   = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    // Immediate format chosen purely from the opcode.
    function automatic logic [SEL_W-1:0] imm_dec(input logic [OP_W-1:0] op);
        case (op)
            OP_SW:   imm_dec = IMM_S;
            OP_BEQ:  imm_dec = IMM_B;
            OP_JAL:  imm_dec = IMM_J;
            default: imm_dec = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/riscv_mc_aludec.sv
// ALU control decoder.
// Ports: aluop (00 add, 01 sub, 10 by funct3), funct3, op5 (Instr[5]),
//        funct7b5 (Instr[30]) -> alu_control_c (combinational ALU operation).
module riscv_mc_aludec
    import riscv_mc_pkg::*;
(
    input  logic [AOP_W-1:0] aluop,
    input  logic [F3_W-1:0]  funct3,
    input  logic             op5,
    input  logic             funct7b5,
    output logic [ALU_W-1:0] alu_control_c
);

    // Subtract only for R-type with funct7[5] set; I-type addi never subtracts.
    always_comb begin
        alu_control_c = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alu_control_c = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control_c = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_c = ALU_SLT;
                    3'b110:  alu_control_c = ALU_OR;
                    3'b111:  alu_control_c = ALU_AND;
                    default: alu_control_c = ALU_ADD;
                endcase
            end
            default: alu_control_c = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multicycle control unit for the RV32I subset (lw, sw, R-type, I-type ALU, beq, jal).
// Inputs : clk, reset (sync, active-high), op, funct3, funct7b5, Zero,
//          MemReady (only when RISCV_MC_MEM_WAIT_EN is defined).
// Outputs: PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//          ImmSrc, ALUControl, RegWrite, IllegalOp, InstrRetired.
// Control outputs are combinational from state and op and forced to 0 while
// reset is high. Define RISCV_MC_MEM_WAIT_EN to stall memory states on MemReady.
module riscv_mc_controller
    import riscv_mc_pkg::*;
#(
    parameter int unsigned RET_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OP_W-1:0]   op,
    input  logic [F3_W-1:0]   funct3,
    input  logic              funct7b5,
    input  logic              Zero,
`ifdef RISCV_MC_MEM_WAIT_EN
    input  logic              MemReady,
`endif
    output logic              PCWrite,
    output logic              AdrSrc,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic [SEL_W-1:0]  ResultSrc,
    output logic [SEL_W-1:0]  ALUSrcA,
    output logic [SEL_W-1:0]  ALUSrcB,
    output logic [SEL_W-1:0]  ImmSrc,
    output logic [ALU_W-1:0]  ALUControl,
    output logic              RegWrite,
    output logic              IllegalOp,
    output logic [RET_W-1:0]  InstrRetired
);

    state_t             state, state_n;
    logic [RET_W-1:0]   ret_cnt;
    logic               mem_ready_c;
    logic               pc_update_c, branch_c, retire_c, illegal_c;
    logic               adr_src_c, mem_write_c, ir_write_c, reg_write_c;
    logic [SEL_W-1:0]   result_src_c, src_a_c, src_b_c;
    logic [AOP_W-1:0]   aluop_c;
    logic [ALU_W-1:0]   alu_control_c;

`ifdef RISCV_MC_MEM_WAIT_EN
    assign mem_ready_c = MemReady;
`else
    assign mem_ready_c = 1'b1;
`endif

    // State and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            ret_cnt <= '0;
        end else begin
            state <= state_n;
            if (retire_c) ret_cnt <= ret_cnt + RET_W'(1);
        end
    end

    // Next-state and per-state control.
    always_comb begin
        state_n      = state;
        pc_update_c  = 1'b0;
        branch_c     = 1'b0;
        retire_c     = 1'b0;
        illegal_c    = 1'b0;
        adr_src_c    = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        result_src_c = RES_ALUOUT;
        src_a_c      = SRCA_PC;
        src_b_c      = SRCB_WD;
        aluop_c      = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                src_b_c      = SRCB_FOUR;
                result_src_c = RES_ALURESULT;
                ir_write_c   = mem_ready_c;
                pc_update_c  = mem_ready_c;
                if (mem_ready_c) state_n = S_DECODE;
            end
            S_DECODE: begin
                src_a_c = SRCA_OLDPC;
                src_b_c = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_R:         state_n = S_EXECR;
                    OP_I:         state_n = S_EXECI;
                    OP_JAL:       state_n = S_JAL;
                    OP_BEQ:       state_n = S_BEQ;
                    default: begin
                        state_n   = S_FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                src_a_c = SRCA_A;
                src_b_c = SRCB_IMM;
                state_n = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src_c = 1'b1;
                if (mem_ready_c) state_n = S_MEMWB;
            end
            S_MEMWB: begin
                result_src_c = RES_DATA;
                reg_write_c  = 1'b1;
                retire_c     = 1'b1;
                state_n      = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src_c   = 1'b1;
                mem_write_c = 1'b1;
                if (mem_ready_c) begin
                    retire_c = 1'b1;
                    state_n  = S_FETCH;
                end
            end
            S_EXECR: begin
                src_a_c = SRCA_A;
                aluop_c = ALUOP_FUNCT;
                state_n = S_ALUWB;
            end
            S_EXECI: begin
                src_a_c = SRCA_A;
                src_b_c = SRCB_IMM;
                aluop_c = ALUOP_FUNCT;
                state_n = S_ALUWB;
            end
            S_JAL: begin
                src_a_c     = SRCA_OLDPC;
                src_b_c     = SRCB_FOUR;
                pc_update_c = 1'b1;
                state_n     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
                state_n     = S_FETCH;
            end
            S_BEQ: begin
                src_a_c  = SRCA_A;
                aluop_c  = ALUOP_SUB;
                branch_c = 1'b1;
                retire_c = 1'b1;
                state_n  = S_FETCH;
            end
            default: state_n = S_FETCH;
        endcase
    end

    riscv_mc_aludec u_aludec (
        .aluop         (aluop_c),
        .funct3        (funct3),
        .op5           (op[5]),
        .funct7b5      (funct7b5),
        .alu_control_c (alu_control_c)
    );

    // All outputs are held at 0 during the reset cycle.
    assign PCWrite      = ~reset & (pc_update_c | (branch_c & Zero));
    assign AdrSrc       = ~reset & adr_src_c;
    assign MemWrite     = ~reset & mem_write_c;
    assign IRWrite      = ~reset & ir_write_c;
    assign RegWrite     = ~reset & reg_write_c;
    assign IllegalOp    = ~reset & illegal_c;
    assign ResultSrc    = reset ? '0 : result_src_c;
    assign ALUSrcA      = reset ? '0 : src_a_c;
    assign ALUSrcB      = reset ? '0 : src_b_c;
    assign ImmSrc       = reset ? '0 : imm_dec(op);
    assign ALUControl   = reset ? '0 : alu_control_c;
    assign InstrRetired = reset ? '0 : ret_cnt;

endmodule
